threshold_stage: RTL
====================

# threshold_stage

Parametrised binarisation stage for the adaptive-thresholding pipeline. It runs when the global sequencer enters its state, streams every pixel address of the image and threshold memories, and compares each pixel against its precomputed local threshold minus a constant. It writes one result per cycle to the result memory. Compared with the first-generation stage it adds configurable pixel width, configurable memory read latency, four output modes, saturating threshold arithmetic, an explicit write strobe, and re-runnable passes.

## Interface
- WIDTH_BITS, 8, column address bits; image width = 2**WIDTH_BITS
- HEIGHT_BITS, 8, row address bits; image height = 2**HEIGHT_BITS
- PIX_BITS, 8, pixel and threshold data width
- C_BITS, 5, width of subtracted constant C (C_BITS ≤ PIX_BITS)
- READ_LATENCY, 1, cycles from address presented to data valid on iImageData/iThresholdData (legal 1..4)
- STATE_ID, 2, global_state value that enables this stage
- clock  in  1  clock, rising edge
- not_reset  in  1  reset, asynchronous, active-low
- global_state  in  3  sequencer state
- mode  in  2  0 BINARY, 1 BINARY_INV, 2 TRUNC, 3 TOZERO
- C  in  C_BITS  constant subtracted from threshold
- oImageCol / oImageRow  out  WIDTH_BITS / HEIGHT_BITS  image read address
- iImageData  in  PIX_BITS  image pixel
- oThresholdCol / oThresholdRow  out  WIDTH_BITS / HEIGHT_BITS  threshold read address (always equal to image address)
- iThresholdData  in  PIX_BITS  local threshold
- oResultCol / oResultRow  out  WIDTH_BITS / HEIGHT_BITS  result write address
- oResultData  out  PIX_BITS  result pixel
- oResultWe  out  1  result write strobe, one pixel per high cycle
- busy  out  1  high in RUN and DRAIN
- finished  out  1  pass complete

## Operation
- States: IDLE, RUN, DRAIN, DONE. pos = {row, col}, with N = 2**(WIDTH_BITS+HEIGHT_BITS).
- IDLE → RUN when global_state == STATE_ID. On that edge: pos ← 0, and mode and C are latched into internal registers, held for the whole pass.
- RUN: presents pos on both read ports and increments pos each cycle. After pos = N−1 is issued, go to DRAIN. pos does not wrap into a second pass.
- A valid/address delay line of depth READ_LATENCY carries each issued address to the compare stage.
- DRAIN: no new addresses are issued; go to DONE when the delay line and the output register are empty.
- DONE: finished = 1. Hold DONE while global_state == STATE_ID. On the first other value, go to IDLE and clear finished, so the next entry starts a new pass.
- Abort: if global_state != STATE_ID in RUN or DRAIN, go to IDLE and flush the delay line. No oResultWe is asserted from the following cycle on, and finished stays 0.
- Arithmetic:
  - T = iThresholdData − C, saturated at 0. No wrap-around; computed at PIX_BITS+1 width.
  - hit = iImageData > T, an unsigned strict compare.
  - MAX = all-ones of PIX_BITS.
- Output per mode:
  - BINARY: hit ? MAX : 0.
  - BINARY_INV: hit ? 0 : MAX.
  - TRUNC: hit ? T : pixel.
  - TOZERO: hit ? pixel : 0.
- Consumers needing 1 bit use oResultData[0] in the binary modes.
- Reset values:
  - state IDLE, pos 0, delay line empty.
  - oResultWe 0, oResultData 0, oResultCol/Row 0.
  - busy 0, finished 0.
- Read addresses equal pos in all states; their value outside RUN is don't-care for memories.

## Timing
- Edge e0 samples global_state == STATE_ID in IDLE. Address k is presented in cycle e0+1+k, for k = 0..N−1.
- Data for address k is sampled at the end of cycle e0+1+k+READ_LATENCY−1, and the result is registered on that edge.
- oResultWe = 1 with oResultCol/Row = k and valid oResultData in cycle e0+1+k+READ_LATENCY. Throughput is one pixel per cycle with no bubbles.
- Exactly N write strobes per completed pass, in ascending address order.
- finished rises in the cycle after the last oResultWe and is registered. busy falls in the same cycle.
- Reset asserted mid-pass: all outputs return to reset values immediately (asynchronous). After release the stage starts a fresh pass only if global_state == STATE_ID.
- Mode/C changes during a pass have no effect until the next pass.

## Test plan
- WIDTH_BITS = HEIGHT_BITS = 2, READ_LATENCY = 1, BINARY, C = 0, thresholds all 128, pixels 120..135 → results 0 for pixels 120..128 and 255 for 129..135. 16 strobes in addresses 0..15; finished in cycle e0+18.
- Saturation: threshold 3, C = 10 → T = 0. Pixel 0 → 0; pixel 1 → 255 (BINARY); BINARY_INV gives 255/0. No wrap-induced all-zero output.
- Modes with threshold 100, C = 4 (T = 96):
  - pixel 200: TRUNC → 96, TOZERO → 200.
  - pixel 50: TRUNC → 50, TOZERO → 0.
  - pixel 96: TRUNC → 96, TOZERO → 0.
- READ_LATENCY = 3 with a memory model of matching delay: write for address k lands in cycle e0+4+k with correct data. finished in cycle e0+20; busy high for exactly 19 cycles.
- Abort/re-run: drop global_state after address 5 is issued → no strobes after the drop cycle, finished 0. Re-enter STATE_ID → a full 16-strobe pass from address 0, then finished. Leave state → finished clears next cycle.
- Reset pulse mid-RUN → oResultWe, finished and busy are 0 immediately. Release with global_state == STATE_ID → a complete new pass of 16 strobes.

Source files
------------

// File: rtl/threshold_stage_if.sv
// Memory-side bus of the binarisation stage: image and threshold read ports
// plus the result write port. The stage drives the master side.
interface threshold_stage_if #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int PIX_BITS    = 8
);
    logic [WIDTH_BITS-1:0]  oImageCol;
    logic [HEIGHT_BITS-1:0] oImageRow;
    logic [PIX_BITS-1:0]    iImageData;

    logic [WIDTH_BITS-1:0]  oThresholdCol;
    logic [HEIGHT_BITS-1:0] oThresholdRow;
    logic [PIX_BITS-1:0]    iThresholdData;

    logic [WIDTH_BITS-1:0]  oResultCol;
    logic [HEIGHT_BITS-1:0] oResultRow;
    logic [PIX_BITS-1:0]    oResultData;
    logic                   oResultWe;

    modport master (
        output oImageCol, oImageRow,
        output oThresholdCol, oThresholdRow,
        output oResultCol, oResultRow, oResultData, oResultWe,
        input  iImageData, iThresholdData
    );

    modport slave (
        input  oImageCol, oImageRow,
        input  oThresholdCol, oThresholdRow,
        input  oResultCol, oResultRow, oResultData, oResultWe,
        output iImageData, iThresholdData
    );
endinterface

// File: rtl/threshold_stage.sv
// Adaptive-threshold binarisation pass: streams every pixel address, compares
// pixel against (local threshold - C) and writes one result per cycle.
module threshold_stage #(
    parameter int WIDTH_BITS   = 8,
    parameter int HEIGHT_BITS  = 8,
    parameter int PIX_BITS     = 8,
    parameter int C_BITS       = 5,
    parameter int READ_LATENCY = 1,
    parameter int STATE_ID     = 2
) (
    input  logic               clock,
    input  logic               not_reset,
    input  logic [2:0]         global_state,
    input  logic [1:0]         mode,
    input  logic [C_BITS-1:0]  C,
    threshold_stage_if.master  mem,
    output logic               busy,
    output logic               finished
);

    localparam int ADDR_BITS = WIDTH_BITS + HEIGHT_BITS;
    localparam int DL_DEPTH  = READ_LATENCY - 1;

    localparam logic [2:0] RUN_STATE_ID = 3'(STATE_ID);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] MODE_BINARY     = 2'd0;
    localparam logic [1:0] MODE_BINARY_INV = 2'd1;
    localparam logic [1:0] MODE_TRUNC      = 2'd2;
    localparam logic [1:0] MODE_TOZERO     = 2'd3;

    localparam logic [PIX_BITS-1:0]  PIX_MAX = '1;
    localparam logic [ADDR_BITS-1:0] POS_ONE = ADDR_BITS'(1);

    // Threshold minus C, clamped at zero; one extra sign bit avoids wrap.
    function automatic logic [PIX_BITS-1:0] sat_threshold(
        input logic [PIX_BITS-1:0] thr,
        input logic [C_BITS-1:0]   c
    );
        logic signed [PIX_BITS:0] diff;
        diff = $signed({1'b0, thr}) - $signed({{(PIX_BITS + 1 - C_BITS){1'b0}}, c});
        if (diff < 0)
            return '0;
        return diff[PIX_BITS-1:0];
    endfunction

    function automatic logic [PIX_BITS-1:0] apply_mode(
        input logic [1:0]          m,
        input logic [PIX_BITS-1:0] pix,
        input logic [PIX_BITS-1:0] t
    );
        logic                hit;
        logic [PIX_BITS-1:0] res;
        hit = pix > t;
        res = '0;
        case (m)
            MODE_BINARY:     res = hit ? PIX_MAX : '0;
            MODE_BINARY_INV: res = hit ? '0 : PIX_MAX;
            MODE_TRUNC:      res = hit ? t : pix;
            MODE_TOZERO:     res = hit ? pix : '0;
            default:         res = '0;
        endcase
        return res;
    endfunction

    logic [1:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] pos_q, pos_d;
    logic [1:0]           mode_q, mode_d;
    logic [C_BITS-1:0]    c_q, c_d;
    logic                 busy_q, busy_d;
    logic                 finished_q, finished_d;
    logic                 we_q, we_d;
    logic [PIX_BITS-1:0]  res_data_q, res_data_d;
    logic [ADDR_BITS-1:0] res_pos_q, res_pos_d;

    logic                 enable;
    logic                 issue;
    logic                 abort;
    logic                 last_pos;
    logic                 tap_vld;
    logic [ADDR_BITS-1:0] tap_pos;
    logic                 dl_empty_d;

    assign enable   = (global_state == RUN_STATE_ID);
    assign issue    = (state_q == S_RUN);
    assign abort    = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !enable;
    assign last_pos = &pos_q;

    // Address/valid delay line: tap lines up with the memory data for that address.
    generate
        if (READ_LATENCY > 1) begin : g_dl
            logic [DL_DEPTH-1:0]  dl_vld_q, dl_vld_d;
            logic [ADDR_BITS-1:0] dl_pos_q [DL_DEPTH];
            logic [ADDR_BITS-1:0] dl_pos_d [DL_DEPTH];

            always_comb begin
                dl_vld_d    = '0;
                dl_vld_d[0] = issue;
                dl_pos_d[0] = pos_q;
                for (int i = 1; i < DL_DEPTH; i++) begin
                    dl_vld_d[i] = dl_vld_q[i-1];
                    dl_pos_d[i] = dl_pos_q[i-1];
                end
                if (abort)
                    dl_vld_d = '0;
            end

            always_ff @(posedge clock or negedge not_reset) begin
                if (!not_reset)
                    dl_vld_q <= '0;
                else
                    dl_vld_q <= dl_vld_d;
            end

            always_ff @(posedge clock) begin
                for (int i = 0; i < DL_DEPTH; i++)
                    dl_pos_q[i] <= dl_pos_d[i];
            end

            assign tap_vld    = dl_vld_q[DL_DEPTH-1];
            assign tap_pos    = dl_pos_q[DL_DEPTH-1];
            assign dl_empty_d = (dl_vld_d == '0);
        end else begin : g_nodl
            assign tap_vld    = issue;
            assign tap_pos    = pos_q;
            assign dl_empty_d = 1'b1;
        end
    endgenerate

    // Compare stage: result registered on the edge that samples the memory data.
    always_comb begin
        we_d       = tap_vld && !abort;
        res_pos_d  = res_pos_q;
        res_data_d = res_data_q;
        if (tap_vld) begin
            res_pos_d  = tap_pos;
            res_data_d = apply_mode(mode_q, mem.iImageData,
                                    sat_threshold(mem.iThresholdData, c_q));
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        mode_d  = mode_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_RUN;
                    pos_d   = '0;
                    mode_d  = mode;
                    c_d     = C;
                end
            end
            S_RUN: begin
                if (abort)
                    state_d = S_IDLE;
                else if (last_pos)
                    state_d = S_DRAIN;
                else
                    pos_d = pos_q + POS_ONE;
            end
            S_DRAIN: begin
                // Leave once nothing will be in flight after this edge.
                if (abort)
                    state_d = S_IDLE;
                else if (dl_empty_d && !we_d)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (!enable)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
        finished_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state_q    <= S_IDLE;
            pos_q      <= '0;
            mode_q     <= MODE_BINARY;
            c_q        <= '0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            we_q       <= 1'b0;
            res_data_q <= '0;
            res_pos_q  <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            mode_q     <= mode_d;
            c_q        <= c_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
            we_q       <= we_d;
            res_data_q <= res_data_d;
            res_pos_q  <= res_pos_d;
        end
    end

    assign mem.oImageCol     = pos_q[WIDTH_BITS-1:0];
    assign mem.oImageRow     = pos_q[ADDR_BITS-1:WIDTH_BITS];
    assign mem.oThresholdCol = pos_q[WIDTH_BITS-1:0];
    assign mem.oThresholdRow = pos_q[ADDR_BITS-1:WIDTH_BITS];
    assign mem.oResultCol    = res_pos_q[WIDTH_BITS-1:0];
    assign mem.oResultRow    = res_pos_q[ADDR_BITS-1:WIDTH_BITS];
    assign mem.oResultData   = res_data_q;
    assign mem.oResultWe     = we_q;

    assign busy     = busy_q;
    assign finished = finished_q;

endmodule
